fpu_dispatch: RTL

- Parametrised successor to the FPU clock-steering control block.
- Replaces per-opcode gated clocks with a registered, handshaked dispatcher on a single free-running clock.
- Accepts one opcode per operation, issues a one-cycle start pulse to the selected arithmetic unit, and waits for that unit's done with a timeout watchdog.
- Returns the selected unit's result, with error status, on a valid/ready output port. Sits between the FPU front-end decoder and the arithmetic units.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_dispatch_timer.sv | 31 +++
 rtl/fpu_dispatch.sv | 119 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and defaults for the FPU dispatcher, decoder and arithmetic units.
package fpu_pkg;

  localparam int unsigned N_UNITS_DEF = 5;
  localparam int unsigned OPC_W_DEF   = 3;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/fpu_dispatch_timer.sv
// Watchdog up-counter: cleared on issue, counts while waiting, flags TIMEOUT-1.
module fpu_dispatch_timer
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt;

  // Count up while enabled; saturate at all-ones so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_dispatch.sv
// Handshaked FPU opcode dispatcher: start pulse, done/timeout wait, result hold.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int unsigned N_UNITS = N_UNITS_DEF,
  parameter int unsigned OPC_W   = OPC_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OPC_W-1:0]            in_opc,
  output logic [N_UNITS-1:0]          unit_start,
  input  logic [N_UNITS-1:0]          unit_done,
  input  logic [N_UNITS*DATA_W-1:0]   unit_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [OPC_W-1:0]            out_opc,
  output logic [1:0]                  out_err,
  output logic                        busy
);

  state_t            state;
  logic [OPC_W-1:0]  sel;
  logic              tc_c;
  logic              legal_c;
  logic              done_sel_c;
  logic [N_UNITS-1:0] dec_c;
  logic [N_UNITS-1:0] hit_c;
  logic [DATA_W-1:0] acc_c [N_UNITS+1];

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign legal_c  = ({1'b0, in_opc} < (OPC_W+1)'(N_UNITS));

  // Per-unit opcode decode and result mux built from indexed part-selects.
  assign acc_c[0] = '0;
  for (genvar k = 0; k < N_UNITS; k++) begin : g_unit
    assign dec_c[k]   = (in_opc == OPC_W'(k));
    assign hit_c[k]   = (sel == OPC_W'(k));
    assign acc_c[k+1] = acc_c[k] | (unit_result[k*DATA_W +: DATA_W] & {DATA_W{hit_c[k]}});
  end

  // Only the selected unit's done strobe matters.
  assign done_sel_c = |(unit_done & hit_c);

  fpu_dispatch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ISSUE),
    .en    (state == WAIT),
    .tc    (tc_c)
  );

  // Dispatch FSM with registered start pulse and result port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      unit_start <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_opc    <= '0;
      out_err    <= ERR_OK;
    end else begin
      unit_start <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sel <= in_opc;
            if (legal_c) begin
              state      <= ISSUE;
              unit_start <= dec_c;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= '0;
              out_opc   <= in_opc;
              out_err   <= ERR_ILLEGAL;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done_sel_c) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_data  <= acc_c[N_UNITS];
            out_opc   <= sel;
            out_err   <= ERR_OK;
          end else if (tc_c) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_data  <= '0;
            out_opc   <= sel;
            out_err   <= ERR_TIMEOUT;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
